// File: rtl/sr_flip_flop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : sr_pkg                                                          |
// | Purpose  : Shared types and next-state rule for the SR flip-flop bank.     |
// |            sr_policy_e selects what a cell does when s and r are both      |
// |            high. sr_next() returns the next stored value of one bit.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sr_pkg;

  typedef enum logic [1:0] {
    SR_HOLD   = 2'd0,
    SR_SET    = 2'd1,
    SR_RESET  = 2'd2,
    SR_TOGGLE = 2'd3
  } sr_policy_e;

  // Next value of one stored bit given its current value and the sampled
  // set/reset requests. The forbidden s=r=1 case is resolved by 'policy'.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_policy_e policy);
    logic w_next;
    w_next = q;
    case ({s, r})
      2'b10:   w_next = 1'b1;
      2'b01:   w_next = 1'b0;
      2'b11: begin
        case (policy)
          SR_SET:    w_next = 1'b1;
          SR_RESET:  w_next = 1'b0;
          SR_TOGGLE: w_next = ~q;
          default:   w_next = q;
        endcase
      end
      default: w_next = q;
    endcase
    return w_next;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_ff_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sr_ff_cell                                                      |
// | Purpose  : Single clocked SR storage bit with complementary output and a   |
// |            registered flag for the s=r=1 input.                            |
// | Ports    : clk      - rising-edge clock                                    |
// |            rst      - synchronous active-high reset (dominates s/r)        |
// |            s, r     - set / reset requests                                 |
// |            q, qbar  - stored state and its complement                      |
// |            both_err - high for the cycle after s=r=1 was sampled           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sr_ff_cell
  import sr_pkg::*;
#(
  parameter sr_policy_e BOTH_POLICY = SR_HOLD,
  parameter logic       RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar,
  output logic both_err
);

  logic r_q;
  logic r_both_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= RESET_VALUE;
      r_both_err <= 1'b0;
    end else begin
      r_q        <= sr_next(r_q, s, r, BOTH_POLICY);
      r_both_err <= s & r;
    end
  end

  // qbar is derived from the single state register so it can never disagree
  // with q, including in the cycle right after reset.
  assign q        = r_q;
  assign qbar     = ~r_q;
  assign both_err = r_both_err;

endmodule
`default_nettype wire

// File: rtl/sr_flip_flop.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sr_flip_flop                                                    |
// | Purpose  : Bank of WIDTH independent clocked SR flip-flops with true and   |
// |            complementary outputs, a configurable s=r=1 policy and a        |
// |            per-bit s=r=1 flag. Leaf storage for control/status latching.   |
// | Params   : WIDTH       - number of bits (>= 1)                             |
// |            BOTH_POLICY - SR_HOLD / SR_SET / SR_RESET / SR_TOGGLE           |
// |            RESET_VALUE - q_out after reset ('0 / '1 fill every bit)        |
// | Ports    : clk      - rising-edge clock                                    |
// |            rst      - synchronous active-high reset                        |
// |            s, r     - per-bit set / reset requests         [WIDTH]         |
// |            q_out    - stored state                         [WIDTH]         |
// |            qbar_out - ~q_out                               [WIDTH]         |
// |            both_err - per-bit flag, s=r=1 seen last edge   [WIDTH]         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int unsigned           WIDTH       = 1,
  parameter sr_policy_e            BOTH_POLICY = SR_HOLD,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] qbar_out,
  output logic [WIDTH-1:0] both_err
);

  // Elaboration-time parameter legality.
  if (WIDTH < 1) begin : g_bad_width
    $error("sr_flip_flop: WIDTH must be at least 1");
  end

  if (!(BOTH_POLICY inside {SR_HOLD, SR_SET, SR_RESET, SR_TOGGLE})) begin : g_bad_policy
    $error("sr_flip_flop: BOTH_POLICY out of range");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    sr_ff_cell #(
      .BOTH_POLICY (BOTH_POLICY),
      .RESET_VALUE (RESET_VALUE[gi])
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .s        (s[gi]),
      .r        (r[gi]),
      .q        (q_out[gi]),
      .qbar     (qbar_out[gi]),
      .both_err (both_err[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_flip_flop.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sr_flip_flop                                                 |
// | Purpose  : Self-checking bench for sr_flip_flop. Four 4-bit instances, one |
// |            per s=r=1 policy, share the same stimulus; a vector-level       |
// |            reference model predicts every output.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sr_flip_flop;
  import sr_pkg::*;

  localparam int NDUT = 4;

  logic       clk;
  logic       rst;
  logic [3:0] s;
  logic [3:0] r;
  logic [3:0] q    [NDUT];
  logic [3:0] qbar [NDUT];
  logic [3:0] berr [NDUT];

  // Reset values per instance; instance 2 uses a mixed pattern.
  localparam logic [3:0] RV0 = 4'b0000;
  localparam logic [3:0] RV1 = 4'b0000;
  localparam logic [3:0] RV2 = 4'b0110;
  localparam logic [3:0] RV3 = 4'b0000;

  sr_flip_flop #(.WIDTH(4), .BOTH_POLICY(SR_HOLD),   .RESET_VALUE(RV0)) u_hold (
    .clk(clk), .rst(rst), .s(s), .r(r), .q_out(q[0]), .qbar_out(qbar[0]), .both_err(berr[0]));
  sr_flip_flop #(.WIDTH(4), .BOTH_POLICY(SR_SET),    .RESET_VALUE(RV1)) u_set (
    .clk(clk), .rst(rst), .s(s), .r(r), .q_out(q[1]), .qbar_out(qbar[1]), .both_err(berr[1]));
  sr_flip_flop #(.WIDTH(4), .BOTH_POLICY(SR_RESET),  .RESET_VALUE(RV2)) u_reset (
    .clk(clk), .rst(rst), .s(s), .r(r), .q_out(q[2]), .qbar_out(qbar[2]), .both_err(berr[2]));
  sr_flip_flop #(.WIDTH(4), .BOTH_POLICY(SR_TOGGLE), .RESET_VALUE(RV3)) u_toggle (
    .clk(clk), .rst(rst), .s(s), .r(r), .q_out(q[3]), .qbar_out(qbar[3]), .both_err(berr[3]));

  int n_checks = 0;
  int n_fail   = 0;
  bit seen_reset = 1'b0;

  // Reference model state.
  logic [3:0] m_q   [NDUT];
  logic [3:0] m_err [NDUT];
  logic [3:0] m_rv  [NDUT];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one edge: outcome for s=r=1 is described per policy as the
  // value the bit takes (old value, 1, 0, or inverted old value).
  task automatic model_edge(input logic rst_i, input logic [3:0] s_i, input logic [3:0] r_i);
    logic [3:0] both, only_s, both_val;
    for (int d = 0; d < NDUT; d++) begin
      if (rst_i) begin
        m_q[d]   = m_rv[d];
        m_err[d] = 4'b0000;
      end else begin
        both   = s_i & r_i;
        only_s = s_i & ~r_i;
        case (d)
          0:       both_val = m_q[d];
          1:       both_val = 4'b1111;
          2:       both_val = 4'b0000;
          default: both_val = ~m_q[d];
        endcase
        m_q[d]   = (m_q[d] & ~(s_i | r_i)) | only_s | (both & both_val);
        m_err[d] = both;
      end
    end
  endtask

  task automatic step(input logic rst_i, input logic [3:0] s_i, input logic [3:0] r_i);
    @(negedge clk);
    rst = rst_i; s = s_i; r = r_i;
    @(posedge clk);
    model_edge(rst_i, s_i, r_i);
    if (rst_i) seen_reset = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("q[%0d]", d),    {28'd0, q[d]},    {28'd0, m_q[d]});
      check($sformatf("qbar[%0d]", d), {28'd0, qbar[d]}, {28'd0, ~m_q[d]});
      check($sformatf("berr[%0d]", d), {28'd0, berr[d]}, {28'd0, m_err[d]});
    end
  endtask

  // Complement invariant, sampled away from the active edge.
  always @(negedge clk) begin
    if (seen_reset) begin
      for (int d = 0; d < NDUT; d++)
        check($sformatf("inv[%0d]", d), {28'd0, qbar[d]}, {28'd0, ~q[d]});
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_rv[0] = RV0; m_rv[1] = RV1; m_rv[2] = RV2; m_rv[3] = RV3;
    for (int d = 0; d < NDUT; d++) begin
      m_q[d] = 'x; m_err[d] = 'x;
    end
    rst = 1'b1; s = 4'b0000; r = 4'b0000;

    // Reset held two edges while set is requested; rst must dominate.
    step(1'b1, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b0000);
    check("rst_q_hold",   {28'd0, q[0]},    32'h0);
    check("rst_qbar_hold",{28'd0, qbar[0]}, 32'hF);
    check("rst_berr_hold",{28'd0, berr[0]}, 32'h0);
    check("rst_q_rv2",    {28'd0, q[2]},    32'h6);
    step(1'b0, 4'b1111, 4'b0000);
    check("post_rst_set", {28'd0, q[0]},    32'hF);

    // Set / reset / hold phases, five edges each.
    for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, 4'b0000);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0000, 4'b0000);
      check("hold_phase", {28'd0, q[0]}, 32'h0);
    end

    // Forbidden input from q=0, five edges.
    step(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 4'b1111);
      check("both_hold_q",  {28'd0, q[0]},    32'h0);
      check("both_berr",    {28'd0, berr[0]}, 32'hF);
      check("both_set_q",   {28'd0, q[1]},    32'hF);
      check("both_toggle",  {28'd0, q[3]},    (i % 2 == 0) ? 32'hF : 32'h0);
    end
    step(1'b0, 4'b0000, 4'b0000);
    check("berr_clear",   {28'd0, berr[3]}, 32'h0);

    // Reset priority over s=r=1 with q=1.
    step(1'b0, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b1111);
    check("rst_prio_q",   {28'd0, q[1]},    32'h0);
    check("rst_prio_berr",{28'd0, berr[1]}, 32'h0);

    // Multi-bit independence with the HOLD policy.
    step(1'b0, 4'b0101, 4'b0011);
    check("mb_q",    {28'd0, q[0]},    32'h4);
    check("mb_qbar", {28'd0, qbar[0]}, 32'hB);
    check("mb_berr", {28'd0, berr[0]}, 32'h1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) == 0), 4'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
